// File: rtl/muxn_rr.sv
// rtl/muxn_rr.sv - N:1 mux with manual or round-robin select and a 1-deep registered output slice
module muxn_rr #(
    parameter int BW   = 8,
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_mode,
    input  logic [SELW-1:0] i_sel,
    input  logic [N-1:0]    i_vld,
    input  logic [N*BW-1:0] i_data,
    output logic [N-1:0]    o_rdy,
    output logic            o_vld,
    output logic [BW-1:0]   o_data,
    output logic [SELW-1:0] o_ch,
    input  logic            i_rdy
);

    logic [SELW-1:0] rr_ptr;
    logic            ld;
    logic            sel_in_range;
    logic            man_found;
    logic            rr_found;
    logic [SELW-1:0] rr_gnt;
    logic            has_gnt;
    logic [SELW-1:0] gnt;
    logic [SELW:0]   cand_sum;
    logic [SELW-1:0] cand;

    assign ld           = !o_vld || i_rdy;
    assign sel_in_range = ({1'b0, i_sel} < (SELW+1)'(N));
    assign man_found    = sel_in_range && i_vld[i_sel];

    // Rotating scan starting at rr_ptr; the first valid channel found wins.
    always_comb begin
        rr_found = 1'b0;
        rr_gnt   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int j = 0; j < N; j++) begin
            cand_sum = {1'b0, rr_ptr} + (SELW+1)'(j);
            if (cand_sum >= (SELW+1)'(N)) begin
                cand_sum = cand_sum - (SELW+1)'(N);
            end
            cand = cand_sum[SELW-1:0];
            if (!rr_found && i_vld[cand]) begin
                rr_found = 1'b1;
                rr_gnt   = cand;
            end
        end
    end

    always_comb begin
        has_gnt = 1'b0;
        gnt     = '0;
        if (ld) begin
            if (i_mode) begin
                has_gnt = rr_found;
                gnt     = rr_gnt;
            end else begin
                has_gnt = man_found;
                gnt     = i_sel;
            end
        end
    end

    assign o_rdy = (i_rstn && has_gnt) ? (N'(1) << gnt) : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_ch   <= '0;
            rr_ptr <= '0;
        end else if (ld) begin
            if (has_gnt) begin
                o_vld  <= 1'b1;
                o_data <= i_data[gnt*BW +: BW];
                o_ch   <= gnt;
                if (i_mode) begin
                    rr_ptr <= (gnt == SELW'(N-1)) ? '0 : gnt + SELW'(1);
                end
            end else begin
                // Output drained (or already empty) with nothing new to load.
                o_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muxn_rr.sv
// tb/tb_muxn_rr.sv - scoreboard bench for muxn_rr
module tb_muxn_rr;

    localparam int BW   = 8;
    localparam int N    = 4;
    localparam int SELW = 2;

    logic            i_clk = 1'b0;
    logic            i_rstn;
    logic            i_mode;
    logic [SELW-1:0] i_sel;
    logic [N-1:0]    i_vld;
    logic [N*BW-1:0] i_data;
    logic [N-1:0]    o_rdy;
    logic            o_vld;
    logic [BW-1:0]   o_data;
    logic [SELW-1:0] o_ch;
    logic            i_rdy;

    int checks = 0;
    int errors = 0;

    logic [BW+SELW-1:0] sb_q[$];
    logic               m_vld   = 1'b0;
    logic               m_known = 1'b0;
    int                 m_ptr   = 0;

    muxn_rr #(.BW(BW), .N(N), .SELW(SELW)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_mode (i_mode),
        .i_sel  (i_sel),
        .i_vld  (i_vld),
        .i_data (i_data),
        .o_rdy  (o_rdy),
        .o_vld  (o_vld),
        .o_data (o_data),
        .o_ch   (o_ch),
        .i_rdy  (i_rdy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational accept and current output against the model,
    // score any output transfer, then advance the model across the edge.
    task automatic cycle(input string tag);
        logic          ld;
        logic          found;
        int            g;
        logic [N-1:0]  exp_rdy;
        logic [BW+SELW-1:0] item;
        #1;
        ld      = !m_vld || i_rdy;
        found   = 1'b0;
        g       = 0;
        exp_rdy = '0;
        if (i_mode) begin
            for (int j = 0; j < N; j++) begin
                if (!found && i_vld[(m_ptr + j) % N]) begin
                    found = 1'b1;
                    g     = (m_ptr + j) % N;
                end
            end
        end else if (int'(i_sel) < N && i_vld[i_sel]) begin
            found = 1'b1;
            g     = int'(i_sel);
        end
        if (!i_rstn || !ld) found = 1'b0;
        if (found) exp_rdy[g] = 1'b1;
        chk({tag, "_rdy"}, 32'(o_rdy), 32'(exp_rdy));
        if (m_known) chk({tag, "_vld"}, 32'(o_vld), 32'(m_vld));
        if (i_rstn && m_vld && i_rdy) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
            end else begin
                item = sb_q.pop_front();
                chk({tag, "_data"}, 32'(o_data), 32'(item[BW+SELW-1:SELW]));
                chk({tag, "_ch"}, 32'(o_ch), 32'(item[SELW-1:0]));
            end
        end
        if (!i_rstn) begin
            m_vld   = 1'b0;
            m_ptr   = 0;
            m_known = 1'b1;
            sb_q.delete();
        end else if (ld) begin
            m_vld = found;
            if (found) begin
                sb_q.push_back({i_data[g*BW +: BW], SELW'(g)});
                if (i_mode) m_ptr = (g == N-1) ? 0 : g + 1;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    logic [BW-1:0]   hold_data;
    logic [SELW-1:0] hold_ch;
    int              rr_seq[6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        i_rstn = 1'b0; i_mode = 1'b0; i_sel = '0; i_vld = '1; i_rdy = 1'b1;
        i_data = 32'h44332211;
        @(posedge i_clk);
        #1;

        // T1 reset
        cycle("t1_r0");
        cycle("t1_r1");
        chk("t1_vld", 32'(o_vld), 32'd0);
        chk("t1_data", 32'(o_data), 32'd0);
        chk("t1_ch", 32'(o_ch), 32'd0);

        // T2 manual select
        i_rstn = 1'b1; i_mode = 1'b0; i_sel = 2'd2; i_vld = 4'b1111;
        i_data = {8'h77, 8'hA5, 8'h33, 8'h11};
        #1;
        chk("t2_rdy", 32'(o_rdy), 32'h4);
        cycle("t2_load");
        chk("t2_vld", 32'(o_vld), 32'd1);
        chk("t2_data", 32'(o_data), 32'hA5);
        chk("t2_ch", 32'(o_ch), 32'd2);

        // T3 round-robin fairness, no bubbles
        i_mode = 1'b1; i_vld = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            i_data = $urandom;
            cycle("t3");
            chk("t3_seq_vld", 32'(o_vld), 32'd1);
            chk("t3_seq_ch", 32'(o_ch), 32'(rr_seq[i]));
        end

        // T4 backpressure then release
        i_rdy = 1'b0;
        hold_data = o_data;
        hold_ch   = o_ch;
        for (int i = 0; i < 5; i++) begin
            i_data = $urandom;
            cycle("t4_stall");
            chk("t4_hold_data", 32'(o_data), 32'(hold_data));
            chk("t4_hold_ch", 32'(o_ch), 32'(hold_ch));
            chk("t4_hold_vld", 32'(o_vld), 32'd1);
        end
        i_rdy = 1'b1;
        cycle("t4_release");
        cycle("t4_next");

        // T5 manual select of an invalid channel, then round-robin with nothing valid
        i_mode = 1'b0; i_sel = 2'd2; i_vld = 4'b1011;
        cycle("t5_sel_drain");
        cycle("t5_sel_idle");
        chk("t5_sel_vld", 32'(o_vld), 32'd0);
        i_mode = 1'b1; i_vld = 4'b1111;
        cycle("t5_refill");
        i_vld = 4'b0000;
        cycle("t5_rr_drain");
        cycle("t5_rr_idle");
        chk("t5_rr_vld", 32'(o_vld), 32'd0);

        // T6 reset mid-stream with pointer moved away from zero
        i_mode = 1'b1; i_vld = 4'b0010; i_data = 32'h00C30000 | 32'h0000B200;
        cycle("t6_prime");
        i_rdy = 1'b0; i_vld = 4'b1111;
        cycle("t6_stall");
        chk("t6_pre_vld", 32'(o_vld), 32'd1);
        i_rstn = 1'b0;
        cycle("t6_reset");
        chk("t6_post_vld", 32'(o_vld), 32'd0);
        i_rstn = 1'b1; i_rdy = 1'b1; i_vld = 4'b1111; i_data = 32'h9C8B7A69;
        #1;
        chk("t6_first_gnt", 32'(o_rdy), 32'h1);
        cycle("t6_after");
        chk("t6_ch", 32'(o_ch), 32'd0);
        i_vld = 4'b0000;
        cycle("t6_drain");
        chk("t6_sb_left", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
